// File: rtl/data_mem_responder.sv
// Data-side responder: byte-lane RAM plus GPIO/timer/status MMIO page.
// Ports: clk, reset (async high), write_direction (byte addr),
//   data_out (store data), MemWrite (store size), SizeLoad (funct3),
//   data_in (load data), gpio_out, timer_irq.
// Optional timer block compiled in with `define DMEM_TIMER_EN.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int GPIO_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       write_direction,
   input  logic [31:0]       data_out,
   input  logic [1:0]        MemWrite,
   input  logic [2:0]        SizeLoad,
   output logic [31:0]       data_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              timer_irq
);

   localparam int IW = $clog2(DEPTH_WORDS);
   localparam int AW = IW + 2;

   localparam logic [1:0] ST_NONE = 2'b00;
   localparam logic [1:0] ST_SB   = 2'b01;
   localparam logic [1:0] ST_SH   = 2'b10;
   localparam logic [1:0] ST_SW   = 2'b11;

   localparam logic [1:0] R_GPIO   = 2'd0;
   localparam logic [1:0] R_COUNT  = 2'd1;
   localparam logic [1:0] R_CMP    = 2'd2;
   localparam logic [1:0] R_STATUS = 2'd3;

   logic [31:0] ram [DEPTH_WORDS];

   logic [31:0]       addr;
   logic              is_ram;
   logic              is_mmio;
   logic [IW-1:0]     widx;
   logic [1:0]        rsel;
   logic              misalign;
   logic              set_mis;
   logic              ram_we;
   logic              mmio_we;
   logic              gpio_we;
   logic              st_we;
   logic [3:0]        be;
   logic [31:0]       wdata;

   logic [GPIO_W-1:0] gpio_q;
   logic [1:0]        status_q;
   logic [31:0]       count_q;
   logic [31:0]       cmp_q;
   logic              match;

   logic [31:0]       rword;
   logic [7:0]        rbyte;
   logic [15:0]       rhalf;

   assign addr    = write_direction;
   // Upper bits all zero implies bit31 clear and addr < DEPTH_WORDS*4.
   assign is_ram  = (addr[31:AW] == '0);
   assign is_mmio = (addr[31:4] == 28'h8000000);
   assign widx    = addr[AW-1:2];
   assign rsel    = addr[3:2];

   assign misalign = ((MemWrite == ST_SH) && addr[0]) ||
                     ((MemWrite == ST_SW) && (addr[1:0] != 2'b00));
   assign set_mis  = misalign;

   assign ram_we  = (MemWrite != ST_NONE) && !misalign && is_ram;
   // MMIO only takes aligned word stores.
   assign mmio_we = (MemWrite == ST_SW) && !misalign && is_mmio;
   assign gpio_we = mmio_we && (rsel == R_GPIO);
   assign st_we   = mmio_we && (rsel == R_STATUS);

   always_comb begin
      be    = 4'b0000;
      wdata = data_out;
      unique case (MemWrite)
         ST_SB: begin
            be[addr[1:0]] = 1'b1;
            wdata = {4{data_out[7:0]}};
         end
         ST_SH: begin
            be    = addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{data_out[15:0]}};
         end
         ST_SW:   be = 4'b1111;
         ST_NONE: be = 4'b0000;
      endcase
   end

   // RAM is not reset; an asserted reset still blocks the store.
   always_ff @(posedge clk) begin
      if (!reset && ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) ram[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gpio_q <= '0;
      end else if (gpio_we) begin
         gpio_q <= data_out[GPIO_W-1:0];
      end
   end

`ifdef DMEM_TIMER_EN
   logic cnt_we;
   logic cmp_we;

   assign cnt_we = mmio_we && (rsel == R_COUNT);
   assign cmp_we = mmio_we && (rsel == R_CMP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         cmp_q   <= '1;
      end else begin
         count_q <= cnt_we ? data_out : count_q + 32'd1;
         if (cmp_we) cmp_q <= data_out;
      end
   end

   assign match = (count_q == cmp_q);
`else
   assign count_q = '0;
   assign cmp_q   = '0;
   assign match   = 1'b0;
`endif

   // Set has priority over write-1-to-clear on both bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         status_q <= 2'b00;
      end else begin
         status_q[0] <= set_mis |
                        (status_q[0] & ~(st_we & data_out[0]));
         status_q[1] <= match |
                        (status_q[1] & ~(st_we & data_out[1]));
      end
   end

   always_comb begin
      rword = '0;
      if (is_ram) begin
         rword = ram[widx];
      end else if (is_mmio) begin
         unique case (rsel)
            R_GPIO:   rword = 32'(gpio_q);
            R_COUNT:  rword = count_q;
            R_CMP:    rword = cmp_q;
            R_STATUS: rword = {30'd0, status_q};
         endcase
      end
   end

   assign rbyte = rword[{addr[1:0], 3'b000} +: 8];
   assign rhalf = addr[1] ? rword[31:16] : rword[15:0];

   always_comb begin
      data_in = rword;
      unique case (SizeLoad)
         3'b000:  data_in = {{24{rbyte[7]}}, rbyte};
         3'b001:  data_in = {{16{rhalf[15]}}, rhalf};
         3'b100:  data_in = {24'd0, rbyte};
         3'b101:  data_in = {16'd0, rhalf};
         default: data_in = rword;
      endcase
   end

   assign gpio_out  = gpio_q;
   assign timer_irq = status_q[1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus pushes expected
// values, a negedge monitor pops and compares them.
module tb_data_mem_responder;

   localparam logic [1:0] NO = 2'b00;
   localparam logic [1:0] SB = 2'b01;
   localparam logic [1:0] SH = 2'b10;
   localparam logic [1:0] SW = 2'b11;
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   localparam int K_DATA = 0;
   localparam int K_GPIO = 1;
   localparam int K_IRQ  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] write_direction;
   logic [31:0] data_out;
   logic [1:0]  MemWrite;
   logic [2:0]  SizeLoad;
   logic [31:0] data_in;
   logic [7:0]  gpio_out;
   logic        timer_irq;

   typedef struct {
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(1024), .GPIO_W(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .write_direction (write_direction),
      .data_out        (data_out),
      .MemWrite        (MemWrite),
      .SizeLoad        (SizeLoad),
      .data_in         (data_in),
      .gpio_out        (gpio_out),
      .timer_irq       (timer_irq)
   );

   always @(negedge clk) begin
      while (sbq.size() > 0) begin
         exp_t e;
         logic [31:0] act;
         e = sbq.pop_front();
         case (e.kind)
            K_GPIO:  act = {24'd0, gpio_out};
            K_IRQ:   act = {31'd0, timer_irq};
            default: act = data_in;
         endcase
         total++;
         if (act !== e.val) begin
            bad++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
   end

   task automatic cyc(input logic [31:0] a, input logic [1:0] mw,
                      input logic [2:0] sl, input logic [31:0] d);
      @(posedge clk);
      #1;
      write_direction = a;
      MemWrite        = mw;
      SizeLoad        = sl;
      data_out        = d;
   endtask

   task automatic expect_v(input int k, input logic [31:0] v,
                           input string n);
      exp_t e;
      e.kind = k;
      e.val  = v;
      e.name = n;
      sbq.push_back(e);
   endtask

   task automatic rd(input logic [31:0] a, input logic [2:0] sl,
                     input logic [31:0] v, input string n);
      cyc(a, NO, sl, 32'd0);
      expect_v(K_DATA, v, n);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      MemWrite = NO;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset           = 1'b1;
      write_direction = 32'd0;
      data_out        = 32'd0;
      MemWrite        = NO;
      SizeLoad        = LW;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      rd(32'h8000000C, LW, 32'h0, "status_rst");
      expect_v(K_GPIO, 32'h0, "gpio_rst");
      expect_v(K_IRQ, 32'h0, "irq_rst");
      rd(32'h80000000, LW, 32'h0, "gpio_rd_rst");
`ifdef DMEM_TIMER_EN
      rd(32'h80000008, LW, 32'hFFFFFFFF, "cmp_rst");
`else
      rd(32'h80000008, LW, 32'h0, "cmp_rst");
`endif

      cyc(32'h10, SW, LW, 32'hDEADBEEF);
      rd(32'h13, LB,  32'hFFFFFFDE, "lb_13");
      rd(32'h13, LBU, 32'h000000DE, "lbu_13");
      rd(32'h12, LH,  32'hFFFFDEAD, "lh_12");
      rd(32'h12, LHU, 32'h0000DEAD, "lhu_12");
      rd(32'h10, LB,  32'hFFFFFFEF, "lb_10");
      rd(32'h11, LBU, 32'h000000BE, "lbu_11");
      rd(32'h10, LHU, 32'h0000BEEF, "lhu_10");
      rd(32'h13, LH,  32'hFFFFDEAD, "lh_odd");
      rd(32'h13, 3'b011, 32'hDEADBEEF, "sl_other");
      rd(32'h12, LW,  32'hDEADBEEF, "lw_unal");

      cyc(32'h11, SB, LW, 32'h12345655);
      expect_v(K_DATA, 32'hDEADBEEF, "same_cycle");
      rd(32'h10, LW, 32'hDEAD55EF, "sb_merge");
      cyc(32'h12, SH, LW, 32'h0000CAFE);
      expect_v(K_DATA, 32'hDEAD55EF, "sh_old");
      rd(32'h10, LW, 32'hCAFE55EF, "sh_merge");

      cyc(32'h20, SW, LW, 32'h11223344);
      cyc(32'h21, SH, LW, 32'h0000AAAA);
      cyc(32'h22, SW, LW, 32'hBBBBBBBB);
      rd(32'h20, LW, 32'h11223344, "mis_nowr");
      rd(32'h8000000C, LW, 32'h1, "mis_flag");
      cyc(32'h8000000C, SW, LW, 32'h1);
      expect_v(K_DATA, 32'h1, "w1c_old");
      rd(32'h8000000C, LW, 32'h0, "w1c_clr");

      cyc(32'h0, SW, LW, 32'h0BADF00D);
      cyc(32'h1000, SW, LW, 32'h99);
      expect_v(K_DATA, 32'h0, "unmap_rd");
      cyc(32'h40000010, SW, LW, 32'h77);
      cyc(32'hFFC, SW, LW, 32'h13579BDF);
      rd(32'h0, LW, 32'h0BADF00D, "no_alias0");
      rd(32'h10, LW, 32'hCAFE55EF, "no_alias10");
      rd(32'hFFC, LW, 32'h13579BDF, "last_word");
      rd(32'h80000010, LW, 32'h0, "past_page");

      cyc(32'h80000000, SW, LW, 32'h1A5);
      expect_v(K_DATA, 32'h0, "gpio_old");
      rd(32'h80000000, LW, 32'hA5, "gpio_rd");
      expect_v(K_GPIO, 32'hA5, "gpio_out");
      cyc(32'h80000000, SB, LW, 32'hFF);
      cyc(32'h80000002, SH, LW, 32'hFFFF);
      rd(32'h80000000, LW, 32'hA5, "gpio_sb_ign");
      expect_v(K_GPIO, 32'hA5, "gpio_out_ign");
      rd(32'h8000000C, LW, 32'h0, "mmio_sb_noflag");

`ifndef DMEM_TIMER_EN
      cyc(32'h80000004, SW, LW, 32'h1234);
      rd(32'h80000004, LW, 32'h0, "count_off");
      rd(32'h80000008, LW, 32'h0, "cmp_off");
      for (int i = 0; i < 1000; i++) begin
         cyc(32'h40000000, NO, LW, 32'd0);
         expect_v(K_IRQ, 32'h0, "irq_off");
      end
      rd(32'h8000000C, LW, 32'h0, "status_off");
`endif

      // Reset asserted mid-cycle during a pending store.
      @(posedge clk);
      #1;
      write_direction = 32'h10;
      MemWrite        = SW;
      SizeLoad        = LW;
      data_out        = 32'h12345678;
      #2;
      reset = 1'b1;
      expect_v(K_GPIO, 32'h0, "gpio_async");
      @(posedge clk);
      #1;
      MemWrite = NO;
      reset    = 1'b0;
      rd(32'h10, LW, 32'hCAFE55EF, "ram_keep");
      rd(32'h80000000, LW, 32'h0, "gpio_rd_rst2");

`ifdef DMEM_TIMER_EN
      pulse_reset();
      cyc(32'h80000008, SW, LW, 32'd5);
      expect_v(K_IRQ, 32'h0, "irq_c1");
      rd(32'h80000004, LW, 32'd2, "count_2");
      rd(32'h80000004, LW, 32'd3, "count_3");
      rd(32'h80000004, LW, 32'd4, "count_4");
      rd(32'h80000004, LW, 32'd5, "count_5");
      expect_v(K_IRQ, 32'h0, "irq_at_eq");
      rd(32'h8000000C, LW, 32'h2, "status_match");
      expect_v(K_IRQ, 32'h1, "irq_set");
      cyc(32'h80000008, SW, LW, 32'd10);
      cyc(32'h8000000C, SW, LW, 32'h2);
      rd(32'h8000000C, LW, 32'h0, "match_clr");
      expect_v(K_IRQ, 32'h0, "irq_clr");
      cyc(32'h8000000C, SW, LW, 32'h2);
      rd(32'h8000000C, LW, 32'h2, "set_beats_clr");
      expect_v(K_IRQ, 32'h1, "irq_set2");
      cyc(32'h80000004, SW, LW, 32'h100);
      rd(32'h80000004, LW, 32'h100, "count_load");
      rd(32'h80000004, LW, 32'h101, "count_inc");
`endif

      repeat (2) @(posedge clk);
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d expected 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
